// File: rtl/patch_fetch_ctrl_pkg.sv
// patch_fetch_pkg: shared types and constants for the patch fetch controller.
//   state_t    - controller FSM states
//   phase_t    - 2-bit address-calculator phase
//   cap_tag_t  - tag carried alongside an outstanding read pair
//   slot_idx() - maps (phase, port) onto a patch slot index
package patch_fetch_pkg;

   localparam int PATCH_WORDS = 8;
   localparam int SLOT_STRIDE = 2;   // two slots (one per read port) per phase
   localparam int SLOT_PORT1  = 0;   // port 1 data lands in the even slot
   localparam int SLOT_PORT2  = 1;   // port 2 data lands in the odd slot

   typedef logic [1:0] phase_t;

   localparam phase_t LAST_PHASE = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_OUT   = 2'd3
   } state_t;

   typedef struct packed {
      logic   valid;
      phase_t phase;
      logic   mask1;
      logic   mask2;
   } cap_tag_t;

   function automatic int slot_idx(input phase_t k, input int port_ofs);
      return SLOT_STRIDE * int'(k) + port_ofs;
   endfunction

endpackage

// File: rtl/patch_fetch_ctrl_if.sv
// patch_fetch_ctrl_if: event, address-calculator, memory and patch signals of
// the patch fetch controller.
//   master - controller side (drives ev_ready, phase, latched coordinates,
//            read strobes, patch outputs, busy)
//   slave  - environment side (event FIFO, calculator, memory, consumer)
interface patch_fetch_ctrl_if
   import patch_fetch_pkg::*;
#(
   parameter int XY_W   = 9,
   parameter int DATA_W = 16
);
   logic                          ev_valid;
   logic                          ev_ready;
   logic [XY_W-1:0]               ev_x;
   logic [XY_W-1:0]               ev_y;
   logic [1:0]                    count_modulo;
   logic [XY_W-1:0]               input_addr_x;
   logic [XY_W-1:0]               input_addr_y;
   logic [XY_W-1:0]               addr1_x;
   logic [XY_W-1:0]               addr1_y;
   logic [XY_W-1:0]               addr2_x;
   logic [XY_W-1:0]               addr2_y;
   logic                          mem_rd_en1;
   logic                          mem_rd_en2;
   logic [DATA_W-1:0]             mem_rd_data1;
   logic [DATA_W-1:0]             mem_rd_data2;
   logic                          patch_valid;
   logic                          patch_ready;
   logic [PATCH_WORDS*DATA_W-1:0] patch_data;
   logic                          busy;

   modport master (
      input  ev_valid, ev_x, ev_y,
      input  addr1_x, addr1_y, addr2_x, addr2_y,
      input  mem_rd_data1, mem_rd_data2,
      input  patch_ready,
      output ev_ready, count_modulo, input_addr_x, input_addr_y,
      output mem_rd_en1, mem_rd_en2,
      output patch_valid, patch_data, busy
   );

   modport slave (
      output ev_valid, ev_x, ev_y,
      output addr1_x, addr1_y, addr2_x, addr2_y,
      output mem_rd_data1, mem_rd_data2,
      output patch_ready,
      input  ev_ready, count_modulo, input_addr_x, input_addr_y,
      input  mem_rd_en1, mem_rd_en2,
      input  patch_valid, patch_data, busy
   );
endinterface

// File: rtl/patch_fetch_ctrl_rd_lat_pipe.sv
// rd_lat_pipe: DEPTH-stage shift register carrying the capture tag
// {valid, phase, mask1, mask2} of each read pair until its data returns.
//   clk, rst - clock and synchronous active-high clear of every stage
//   din      - tag of the read pair strobed this cycle
//   dout     - tag of the read pair whose data is on the memory bus now
module rd_lat_pipe
   import patch_fetch_pkg::*;
#(
   parameter int DEPTH = 1
)(
   input  logic     clk,
   input  logic     rst,
   input  cap_tag_t din,
   output cap_tag_t dout
);

   cap_tag_t stage_r [DEPTH];

   // Shift the tag one stage per cycle; reset drops every in-flight tag.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_r[i] <= '0;
         end
      end else begin
         stage_r[0] <= din;
         for (int i = 1; i < DEPTH; i++) begin
            stage_r[i] <= stage_r[i-1];
         end
      end
   end

   assign dout = stage_r[DEPTH-1];

endmodule

// File: rtl/patch_fetch_ctrl.sv
// patch_fetch_ctrl: sequences the event-neighbourhood address calculator
// through phases 0..3 for each accepted event, issues paired memory reads on
// the calculator's registered addresses and assembles the 8 returned words
// into a patch for the activation builder.
//   clk, rst - clock; synchronous active-high reset
//   bus      - patch_fetch_ctrl_if.master (event in, calculator phase and
//              coordinates, memory strobes/data, patch out, busy)
// Optional build macro PATCH_BOUNDS_MASK_EN: suppress strobes for addresses
// outside SENSOR_W x SENSOR_H and store 0 in the corresponding slots.
module patch_fetch_ctrl
   import patch_fetch_pkg::*;
#(
   parameter int CAVIAR_X_Y_BITS = 9,
   parameter int DATA_W          = 16,
   parameter int RD_LAT          = 1,
   parameter int SENSOR_W        = 346,
   parameter int SENSOR_H        = 260
)(
   input  logic               clk,
   input  logic               rst,
   patch_fetch_ctrl_if.master bus
);

   localparam int XY_W = CAVIAR_X_Y_BITS;

   state_t                        state_r, state_s;
   phase_t                        phase_r, phase_s;
   logic                          ev_ready_r, ev_ready_s;
   logic                          busy_r, busy_s;
   logic                          patch_valid_r, patch_valid_s;
   logic                          accept_s;
   logic [XY_W-1:0]               in_x_r, in_y_r;
   logic [PATCH_WORDS*DATA_W-1:0] patch_data_r;
   logic                          issue_d_r;
   phase_t                        issue_phase_r;
   logic                          mask1_s, mask2_s;
   cap_tag_t                      tag_in_s, tag_out_s;

   // Next state, next phase and the registered status outputs.
   always_comb begin
      state_s  = state_r;
      phase_s  = 2'd0;
      accept_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (bus.ev_valid) begin
               accept_s = 1'b1;
               state_s  = ST_ISSUE;
            end else begin
               state_s  = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (phase_r == LAST_PHASE) begin
               state_s = ST_DRAIN;
            end else begin
               phase_s = phase_r + 2'd1;
            end
         end
         ST_DRAIN: begin
            // The phase-3 pair is the last to return; its capture ends the patch.
            if (tag_out_s.valid && (tag_out_s.phase == LAST_PHASE)) begin
               state_s = ST_OUT;
            end else begin
               state_s = ST_DRAIN;
            end
         end
         ST_OUT: begin
            if (bus.patch_ready) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_OUT;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
      ev_ready_s    = (state_s == ST_IDLE);
      busy_s        = (state_s != ST_IDLE);
      patch_valid_s = (state_s == ST_OUT);
   end

   // FSM state, phase and status output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= ST_IDLE;
         phase_r       <= 2'd0;
         ev_ready_r    <= 1'b1;
         busy_r        <= 1'b0;
         patch_valid_r <= 1'b0;
      end else begin
         state_r       <= state_s;
         phase_r       <= phase_s;
         ev_ready_r    <= ev_ready_s;
         busy_r        <= busy_s;
         patch_valid_r <= patch_valid_s;
      end
   end

   // Hold the accepted event's coordinates on the calculator inputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         in_x_r <= {XY_W{1'b0}};
         in_y_r <= {XY_W{1'b0}};
      end else if (accept_s) begin
         in_x_r <= bus.ev_x;
         in_y_r <= bus.ev_y;
      end else begin
         in_x_r <= in_x_r;
         in_y_r <= in_y_r;
      end
   end

   // The calculator registers its addresses one cycle after seeing a phase,
   // so the issue flag and its phase are delayed by the same single stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         issue_d_r     <= 1'b0;
         issue_phase_r <= 2'd0;
      end else begin
         issue_d_r     <= (state_r == ST_ISSUE);
         issue_phase_r <= phase_r;
      end
   end

`ifdef PATCH_BOUNDS_MASK_EN
   localparam logic [XY_W:0] X_LIM = (XY_W+1)'(SENSOR_W);
   localparam logic [XY_W:0] Y_LIM = (XY_W+1)'(SENSOR_H);

   // Unsigned range check; wrapped negative coordinates land far above the limit.
   always_comb begin
      mask1_s = 1'b0;
      mask2_s = 1'b0;
      if (({1'b0, bus.addr1_x} >= X_LIM) || ({1'b0, bus.addr1_y} >= Y_LIM)) begin
         mask1_s = 1'b1;
      end else begin
         mask1_s = 1'b0;
      end
      if (({1'b0, bus.addr2_x} >= X_LIM) || ({1'b0, bus.addr2_y} >= Y_LIM)) begin
         mask2_s = 1'b1;
      end else begin
         mask2_s = 1'b0;
      end
   end
`else
   // Without bounds masking every issued pair is read and stored as returned.
   always_comb begin
      mask1_s = 1'b0;
      mask2_s = 1'b0;
   end
`endif

   // The mask gates the registered strobe because the addresses it checks
   // only become valid in the strobe cycle itself.
   assign bus.mem_rd_en1 = issue_d_r & ~mask1_s;
   assign bus.mem_rd_en2 = issue_d_r & ~mask2_s;

   // Tag entering the read-latency pipe alongside each strobed pair.
   always_comb begin
      tag_in_s       = '0;
      tag_in_s.valid = issue_d_r;
      tag_in_s.phase = issue_phase_r;
      tag_in_s.mask1 = mask1_s;
      tag_in_s.mask2 = mask2_s;
   end

   rd_lat_pipe #(
      .DEPTH (RD_LAT)
   ) u_rd_lat_pipe (
      .clk  (clk),
      .rst  (rst),
      .din  (tag_in_s),
      .dout (tag_out_s)
   );

   // Patch assembly: cleared on accept, phase k data into slots 2k / 2k+1.
   always_ff @(posedge clk) begin
      if (rst) begin
         patch_data_r <= {(PATCH_WORDS*DATA_W){1'b0}};
      end else if (accept_s) begin
         patch_data_r <= {(PATCH_WORDS*DATA_W){1'b0}};
      end else if (tag_out_s.valid) begin
         patch_data_r[slot_idx(tag_out_s.phase, SLOT_PORT1)*DATA_W +: DATA_W] <=
            tag_out_s.mask1 ? {DATA_W{1'b0}} : bus.mem_rd_data1;
         patch_data_r[slot_idx(tag_out_s.phase, SLOT_PORT2)*DATA_W +: DATA_W] <=
            tag_out_s.mask2 ? {DATA_W{1'b0}} : bus.mem_rd_data2;
      end else begin
         patch_data_r <= patch_data_r;
      end
   end

   assign bus.ev_ready     = ev_ready_r;
   assign bus.busy         = busy_r;
   assign bus.patch_valid  = patch_valid_r;
   assign bus.patch_data   = patch_data_r;
   assign bus.count_modulo = phase_r;
   assign bus.input_addr_x = in_x_r;
   assign bus.input_addr_y = in_y_r;

endmodule

// File: tb/tb_patch_fetch_ctrl.sv
// tb_patch_fetch_ctrl: bench for patch_fetch_ctrl with a behavioural address
// calculator (neighbour offsets per phase), an RD_LAT-deep memory returning
// address-derived words, and a patch reference model computed from event
// coordinates. Honors PATCH_BOUNDS_MASK_EN and the RD_LAT parameter.
module tb_patch_fetch_ctrl;
   import patch_fetch_pkg::*;

   parameter int RD_LAT = 1;
   localparam int XY = 9;
   localparam int DW = 16;
   localparam int SW = 346;
   localparam int SH = 260;
   localparam int PV_M = 6 + RD_LAT;   // sample index where patch_valid rises

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   passed = 0;
   int   salt   = 0;

   always #5 clk = ~clk;

   patch_fetch_ctrl_if #(.XY_W(XY), .DATA_W(DW)) bus ();

   patch_fetch_ctrl #(
      .CAVIAR_X_Y_BITS (XY),
      .DATA_W          (DW),
      .RD_LAT          (RD_LAT),
      .SENSOR_W        (SW),
      .SENSOR_H        (SH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic logic [8:0] off(input logic [8:0] v, input int d);
      return 9'(int'(v) + d);
   endfunction

   function automatic logic [DW-1:0] mem_word(input int port, input logic [8:0] x, input logic [8:0] y);
      return 16'(int'(x) * 31 + int'(y) * 17 + port * 4099 + salt);
   endfunction

   function automatic logic in_range(input logic [8:0] x, input logic [8:0] y);
`ifdef PATCH_BOUNDS_MASK_EN
      return (int'(x) < SW) && (int'(y) < SH);
`else
      return 1'b1;
`endif
   endfunction

   // Phase k neighbourhood: port 1 at (x+k-3, y+k), port 2 at (x+k, y+k-3).
   function automatic logic [8*DW-1:0] model_patch(input logic [8:0] x, input logic [8:0] y);
      logic [8*DW-1:0] p;
      p = '0;
      for (int k = 0; k < 4; k++) begin
         if (in_range(off(x, k - 3), off(y, k)))
            p[(2*k)*DW +: DW] = mem_word(1, off(x, k - 3), off(y, k));
         if (in_range(off(x, k), off(y, k - 3)))
            p[(2*k+1)*DW +: DW] = mem_word(2, off(x, k), off(y, k - 3));
      end
      return p;
   endfunction

   // Address calculator model: one register stage after the phase input.
   always @(posedge clk) begin
      bus.addr1_x <= off(bus.input_addr_x, int'(bus.count_modulo) - 3);
      bus.addr1_y <= off(bus.input_addr_y, int'(bus.count_modulo));
      bus.addr2_x <= off(bus.input_addr_x, int'(bus.count_modulo));
      bus.addr2_y <= off(bus.input_addr_y, int'(bus.count_modulo) - 3);
   end

   logic [DW-1:0] mq1 [RD_LAT];
   logic [DW-1:0] mq2 [RD_LAT];

   // Memory model: RD_LAT register stages; unstrobed cycles return junk.
   always @(posedge clk) begin
      mq1[0] <= bus.mem_rd_en1 ? mem_word(1, bus.addr1_x, bus.addr1_y) : 16'hBAD1;
      mq2[0] <= bus.mem_rd_en2 ? mem_word(2, bus.addr2_x, bus.addr2_y) : 16'hBAD2;
      for (int i = 1; i < RD_LAT; i++) begin
         mq1[i] <= mq1[i-1];
         mq2[i] <= mq2[i-1];
      end
   end

   assign bus.mem_rd_data1 = mq1[RD_LAT-1];
   assign bus.mem_rd_data2 = mq2[RD_LAT-1];

   // One event end to end with per-cycle timing checks; hold = extra OUT cycles.
   task automatic run_event(input logic [8:0] x, input logic [8:0] y, input int hold);
      int waitc;
      int k;
      logic e1, e2;
      logic [8*DW-1:0] exp_p;
      salt  = int'($urandom_range(0, 65535));
      exp_p = model_patch(x, y);
      waitc = 0;
      @(negedge clk);
      while (bus.ev_ready !== 1'b1 && waitc < 20) begin
         @(negedge clk);
         waitc++;
      end
      checks++;
      if (bus.ev_ready !== 1'b1) $display("FAIL ev_ready_wait: got %b want 1", bus.ev_ready);
      else passed++;
      ev_drive(1'b1, x, y);
      bus.patch_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      bus.ev_valid = 1'b0;
      for (int m = 1; m <= PV_M + hold; m++) begin
         if (m > 1) @(negedge clk);
         if (m == 1) begin
            checks++;
            if ({bus.input_addr_x, bus.input_addr_y} !== {x, y})
               $display("FAIL input_addr: got (%0d,%0d) want (%0d,%0d)", bus.input_addr_x, bus.input_addr_y, x, y);
            else passed++;
         end
         if (m <= 4) begin
            checks++;
            if (bus.count_modulo !== 2'(m - 1))
               $display("FAIL count_modulo m=%0d: got %0d want %0d", m, bus.count_modulo, m - 1);
            else passed++;
         end
         k  = m - 2;
         e1 = (m >= 2 && m <= 5) ? in_range(off(x, k - 3), off(y, k)) : 1'b0;
         e2 = (m >= 2 && m <= 5) ? in_range(off(x, k), off(y, k - 3)) : 1'b0;
         checks++;
         if ({bus.mem_rd_en1, bus.mem_rd_en2} !== {e1, e2})
            $display("FAIL strobes m=%0d: got %b%b want %b%b", m, bus.mem_rd_en1, bus.mem_rd_en2, e1, e2);
         else passed++;
         checks++;
         if ({bus.busy, bus.ev_ready} !== 2'b10)
            $display("FAIL busy_ready m=%0d: got %b%b want 10", m, bus.busy, bus.ev_ready);
         else passed++;
         checks++;
         if (bus.patch_valid !== (m >= PV_M))
            $display("FAIL patch_valid m=%0d: got %b want %b", m, bus.patch_valid, m >= PV_M);
         else passed++;
         if (m >= PV_M) begin
            checks++;
            if (bus.patch_data !== exp_p)
               $display("FAIL patch_data m=%0d: got %h want %h", m, bus.patch_data, exp_p);
            else passed++;
         end
      end
      bus.patch_ready = 1'b1;
      @(negedge clk);
      bus.patch_ready = 1'b0;
      checks++;
      if ({bus.ev_ready, bus.busy, bus.patch_valid} !== 3'b100)
         $display("FAIL handshake_idle: got %b want 100", {bus.ev_ready, bus.busy, bus.patch_valid});
      else passed++;
   endtask

   task automatic ev_drive(input logic v, input logic [8:0] x, input logic [8:0] y);
      bus.ev_valid = v;
      bus.ev_x     = x;
      bus.ev_y     = y;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.ev_ready, bus.count_modulo, bus.input_addr_x, bus.input_addr_y, bus.mem_rd_en1,
           bus.mem_rd_en2, bus.patch_valid, bus.busy} !== {1'b1, 2'd0, 9'd0, 9'd0, 4'd0})
         $display("FAIL reset_outputs: got ready=%b cm=%0d x=%0d y=%0d en=%b%b pv=%b busy=%b want 1 0 0 0 00 0 0",
                  bus.ev_ready, bus.count_modulo, bus.input_addr_x, bus.input_addr_y,
                  bus.mem_rd_en1, bus.mem_rd_en2, bus.patch_valid, bus.busy);
      else passed++;
      checks++;
      if (bus.patch_data !== '0) $display("FAIL reset_patch_data: got %h want 0", bus.patch_data);
      else passed++;
      rst = 1'b0;
   endtask

   task automatic test_basic();
      run_event(9'd100, 9'd50, 0);
      run_event(9'd1, 9'd1, 0);
      run_event(9'd0, 9'd0, 1);
      run_event(9'd511, 9'd511, 0);
      run_event(9'd345, 9'd259, 0);
      run_event(9'd346, 9'd260, 2);
   endtask

   task automatic test_backpressure();
      run_event(9'(int'($urandom_range(0, 511))), 9'(int'($urandom_range(0, 511))), 10);
   endtask

   task automatic test_back_to_back();
      logic [8:0] qx [$];
      logic [8:0] qy [$];
      logic [8*DW-1:0] expq [$];
      logic [8*DW-1:0] e;
      logic acc;
      int idx, cyc, last_acc, got;
      for (int i = 0; i < 4; i++) begin
         qx.push_back(9'(int'($urandom_range(0, 511))));
         qy.push_back(9'(int'($urandom_range(0, 511))));
      end
      salt = int'($urandom_range(0, 65535));
      @(negedge clk);
      bus.patch_ready = 1'b1;
      ev_drive(1'b1, qx[0], qy[0]);
      idx = 0; got = 0; last_acc = -1; cyc = 0;
      while (got < 4 && cyc < 200) begin
         acc = bus.ev_valid && bus.ev_ready;
         if (bus.patch_valid === 1'b1) begin
            checks++;
            if (expq.size() == 0) begin
               $display("FAIL b2b_patch: got unexpected patch %h want none", bus.patch_data);
            end else begin
               e = expq.pop_front();
               if (bus.patch_data !== e) $display("FAIL b2b_patch %0d: got %h want %h", got, bus.patch_data, e);
               else passed++;
            end
            got++;
         end
         if (acc) begin
            expq.push_back(model_patch(qx[idx], qy[idx]));
            if (last_acc >= 0) begin
               checks++;
               if (cyc - last_acc != 7 + RD_LAT)
                  $display("FAIL b2b_period: got %0d want %0d", cyc - last_acc, 7 + RD_LAT);
               else passed++;
            end
            last_acc = cyc;
            idx++;
         end
         @(negedge clk);
         cyc++;
         if (acc) begin
            if (idx < 4) ev_drive(1'b1, qx[idx], qy[idx]);
            else bus.ev_valid = 1'b0;
         end
      end
      checks++;
      if (got != 4 || idx != 4) $display("FAIL b2b_count: got %0d patches/%0d accepts want 4/4", got, idx);
      else passed++;
      bus.ev_valid    = 1'b0;
      bus.patch_ready = 1'b0;
   endtask

   task automatic test_mid_reset();
      @(negedge clk);
      ev_drive(1'b1, 9'd200, 9'd100);
      @(posedge clk);
      @(negedge clk);                  // m=1
      bus.ev_valid = 1'b0;
      repeat (2) @(negedge clk);       // m=3: phase 2
      checks++;
      if (bus.count_modulo !== 2'd2) $display("FAIL midrst_phase: got %0d want 2", bus.count_modulo);
      else passed++;
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({bus.ev_ready, bus.count_modulo, bus.input_addr_x, bus.input_addr_y, bus.mem_rd_en1,
           bus.mem_rd_en2, bus.patch_valid, bus.busy} !== {1'b1, 2'd0, 9'd0, 9'd0, 4'd0})
         $display("FAIL midrst_outputs: got ready=%b cm=%0d en=%b%b pv=%b busy=%b want 1 0 00 0 0",
                  bus.ev_ready, bus.count_modulo, bus.mem_rd_en1, bus.mem_rd_en2, bus.patch_valid, bus.busy);
      else passed++;
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         checks++;
         if ({bus.mem_rd_en1, bus.mem_rd_en2, bus.patch_valid, bus.busy} !== 4'b0000 || bus.patch_data !== '0)
            $display("FAIL midrst_quiet %0d: got en=%b%b pv=%b busy=%b data=%h want all 0",
                     i, bus.mem_rd_en1, bus.mem_rd_en2, bus.patch_valid, bus.busy, bus.patch_data);
         else passed++;
      end
      run_event(9'd20, 9'd30, 0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 6; i++) begin
         run_event(9'(int'($urandom_range(0, 511))), 9'(int'($urandom_range(0, 511))),
                   int'($urandom_range(0, 3)));
      end
   endtask

   initial begin
      rst             = 1'b1;
      bus.ev_valid    = 1'b0;
      bus.ev_x        = 9'd0;
      bus.ev_y        = 9'd0;
      bus.patch_ready = 1'b0;
      test_reset();
      test_basic();
      test_backpressure();
      test_back_to_back();
      test_mid_reset();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/patch_fetch_ctrl.md
Name: patch_fetch_ctrl

Overview:
Sequencer for the event-neighbourhood address calculator (`addr_calc`). On each accepted event it:
- holds the event coordinates on the calculator inputs;
- steps the calculator's 2-bit phase through 0..3;
- issues paired memory reads on the calculator's registered addresses;
- collects the 8 returned words into a patch for the MLP activation builder.

It sits between the event FIFO and the timestamp/activation memory.

Parameters:
CAVIAR_X_Y_BITS, 9, coordinate width.
DATA_W, 16, memory word width.
RD_LAT, 1, memory read latency in cycles (>=1).
SENSOR_W, 346, valid x range 0..SENSOR_W-1 (used only with the optional feature).
SENSOR_H, 260, valid y range 0..SENSOR_H-1 (used only with the optional feature).

Ports:
clk  in  1  clock; all logic on posedge.
rst  in  1  synchronous, active-high reset.
ev_valid  in  1  event present.
ev_ready  out  1  controller can accept an event.
ev_x, ev_y  in  CAVIAR_X_Y_BITS  event coordinates.
count_modulo  out  2  phase to the address calculator.
input_addr_x, input_addr_y  out  CAVIAR_X_Y_BITS  latched event coordinates to the calculator.
addr1_x, addr1_y, addr2_x, addr2_y  in  CAVIAR_X_Y_BITS  registered calculator outputs.
mem_rd_en1, mem_rd_en2  out  1  read strobes for the address pairs.
mem_rd_data1, mem_rd_data2  in  DATA_W  read data, valid RD_LAT cycles after the strobe.
patch_valid  out  1  patch complete.
patch_ready  in  1  consumer accepts the patch.
patch_data  out  8*DATA_W  slot i at bits [i*DATA_W +: DATA_W].
busy  out  1  state != IDLE.

Behaviour:
- Reset values: ev_ready=1, count_modulo=0, input_addr_x/y=0, mem_rd_en1/2=0, patch_valid=0, patch_data=0, busy=0.
- FSM states: IDLE, ISSUE, DRAIN, OUT.
- IDLE:
  - ev_ready=1.
  - On ev_valid, latch ev_x/ev_y into input_addr_x/y, clear patch_data, set phase=0 and go to ISSUE.
- ISSUE (4 cycles):
  - count_modulo = 0,1,2,3 on consecutive cycles.
  - After phase 3, go to DRAIN.
- Read strobes:
  - A one-bit issue flag is delayed by 1 cycle to match the calculator's register stage.
  - mem_rd_en1/2 are high in each of the 4 cycles after the ISSUE cycles.
- Data capture:
  - The strobe plus phase tag is delayed RD_LAT further.
  - Phase k data1 is written to slot 2k; data2 is written to slot 2k+1.
- DRAIN: leave when the last capture occurs, then go to OUT.
- OUT: patch_valid=1 and patch_data is stable until patch_ready; on the handshake go to IDLE.
- Latency: event accepted at edge A gives patch_valid high from cycle A+6+RD_LAT (A+7 at default).
- Throughput: one event per 7+RD_LAT cycles when patch_ready is held high.
- ev_ready is high only in IDLE. An event presented during ISSUE/DRAIN/OUT is held off, never dropped.
- patch_ready while not in OUT is ignored.
- Reset mid-operation (any state): return to IDLE next cycle, clear the delay-line valid bits, and produce no further captures or strobes.
- Address arithmetic belongs to the calculator. Coordinates wrap modulo 2^CAVIAR_X_Y_BITS; the controller does no arithmetic on them without the optional feature.

Optional Feature:
Macro: PATCH_BOUNDS_MASK_EN.
- Defined:
  - Each issued address pair is compared against SENSOR_W/SENSOR_H, unsigned. Wrapped negatives are out of range.
  - An out-of-range port gets its strobe suppressed, and its slot is written 0 at capture time. The mask bit travels in the delay line.
- Undefined:
  - Both strobes always fire and raw data is stored.
  - SENSOR_W/SENSOR_H are unused.

Decomposition:
- Package patch_fetch_pkg holds:
  - state enum typedef;
  - PATCH_WORDS=8;
  - phase_t (2-bit) typedef;
  - slot-index helper constants.
- One sub-module, rd_lat_pipe: a parameterised shift register of {valid, phase, mask1, mask2}, depth RD_LAT, synchronous clear on rst.

Test Plan:
1. Reset, then event (100,50) with memory returning {phase,port} tags, RD_LAT=1 -> count_modulo 0,1,2,3 on cycles A+1..A+4; strobes on A+2..A+5; patch_valid at A+7; slot 2k = tag{k,1}, slot 2k+1 = tag{k,2}.
2. ev_valid held high with patch_ready tied 1 -> events accepted every 8 cycles (RD_LAT=1); ev_ready low on all intervening cycles; no event lost.
3. patch_ready low for 10 cycles in OUT -> patch_valid and patch_data stable; ev_ready stays 0; handshake returns to IDLE.
4. rst asserted at phase 2 of ISSUE -> next cycle all outputs at reset values; no strobes or captures afterwards; next event produces a correct patch.
5. RD_LAT=3 build -> patch_valid at A+9; slot contents correct.
6. PATCH_BOUNDS_MASK_EN with event (1,1) -> x-3 wraps to 510 >= 346; the corresponding strobes are low and those slots are 0; in-range slots hold memory data.
